// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serializer.
// Bytes queue while a frame is on the line and are sent in order.
module uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // A write while full is dropped even if the serializer pops that same cycle.
  assign o_Tx_Ready   = (count < FULL);
  assign o_Fifo_Count = count;
  assign push         = i_Tx_DV && o_Tx_Ready;
  assign pop          = (state == IDLE) && (count != '0);

  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_Tx_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Done   <= 1'b0;
          clk_cnt     <= '0;
          bit_idx     <= '0;
          if (pop) begin
            shift       <= mem[rd_ptr];
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt     <= '0;
            bit_idx     <= '0;
            o_Tx_Serial <= shift[0];
            state       <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_Tx_Serial <= 1'b1;
              state       <= STOP;
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              o_Tx_Serial <= shift[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt     <= '0;
            o_Tx_Done   <= 1'b1;
            o_Tx_Active <= 1'b0;
            state       <= CLEANUP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        CLEANUP: begin
          o_Tx_Done   <= 1'b0;
          o_Tx_Serial <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4, with a
// line-level receiver model decoding every frame it sees.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic [7:0] tx_byte;
  logic       ready, serial, active, done;
  logic [2:0] fcount;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(ready), .o_Tx_Serial(serial), .o_Tx_Active(active),
    .o_Tx_Done(done), .o_Fifo_Count(fcount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receiver model: falling edge from idle, then sample mid-bit.
  typedef struct {
    logic [7:0] d;
    int         t;
    logic       stop;
  } rx_t;
  rx_t        rxq[$];
  logic [7:0] rx_d;
  int         rx_t0;

  always begin
    @(negedge clk);
    if (!rst && serial === 1'b0) begin
      rx_t0 = cyc;
      repeat (CPB/2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        rx_d[k] = serial;
      end
      repeat (CPB) @(negedge clk);
      rxq.push_back('{d: rx_d, t: rx_t0, stop: serial});
    end
  end

  // Vector table: byte pushed and line pattern, MSB = first symbol on the wire.
  typedef struct {
    logic [7:0] din;
    logic [9:0] pat;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int bad, dseen, w;
    logic exp_s;

    vecs[0] = '{8'hA5, 10'b0101001011};
    vecs[1] = '{8'h00, 10'b0000000001};
    vecs[2] = '{8'hFF, 10'b0111111111};
    vecs[3] = '{8'h01, 10'b0100000001};
    vecs[4] = '{8'h80, 10'b0000000011};
    vecs[5] = '{8'h3C, 10'b0001111001};
    vecs[6] = '{8'h55, 10'b0101010101};

    rst = 1'b1; dv = 1'b0; tx_byte = 8'h00;
    repeat (3) tick();
    chk("rst_serial", 32'(serial), 1);
    chk("rst_active", 32'(active), 0);
    chk("rst_done",   32'(done),   0);
    chk("rst_count",  32'(fcount), 0);
    chk("rst_ready",  32'(ready),  1);
    rst = 1'b0;

    bad = 0; dseen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (serial !== 1'b1) bad++;
      if (done !== 1'b0) dseen++;
    end
    chk("idle_line_bad_cycles", 32'(bad), 0);
    chk("idle_done_cycles", 32'(dseen), 0);
    chk("idle_ready", 32'(ready), 1);
    chk("idle_count", 32'(fcount), 0);

    // Single frames from idle, checked every cycle.
    foreach (vecs[v]) begin
      rxq.delete();
      dv = 1'b1; tx_byte = vecs[v].din;
      tick();
      dv = 1'b0;
      chk($sformatf("v%0d_count_after_push", v), 32'(fcount), 1);
      chk($sformatf("v%0d_line_before_start", v), 32'(serial), 1);
      tick();
      chk($sformatf("v%0d_count_after_pop", v), 32'(fcount), 0);
      for (int j = 0; j < 42; j++) begin
        exp_s = (j < 40) ? vecs[v].pat[9 - j/CPB] : 1'b1;
        chk($sformatf("v%0d_serial_c%0d", v, j), 32'(serial), 32'(exp_s));
        chk($sformatf("v%0d_active_c%0d", v, j), 32'(active), (j < 40) ? 1 : 0);
        chk($sformatf("v%0d_done_c%0d", v, j), 32'(done), (j == 40) ? 1 : 0);
        tick();
      end
      chk($sformatf("v%0d_rx_frames", v), 32'(rxq.size()), 1);
      if (rxq.size() > 0) chk($sformatf("v%0d_rx_byte", v), 32'(rxq[0].d), 32'(vecs[v].din));
    end

    // Burst of six into a depth-4 FIFO, then a push exactly at the pop edge while full.
    rxq.delete();
    for (int i = 1; i <= 5; i++) begin
      dv = 1'b1; tx_byte = 8'(i);
      tick();
    end
    chk("burst_ready_full", 32'(ready), 0);
    chk("burst_count_full", 32'(fcount), 4);
    tx_byte = 8'h06;
    tick();
    dv = 1'b0;
    chk("burst_count_after_drop", 32'(fcount), 4);
    repeat (37) tick();
    chk("popedge_count_before", 32'(fcount), 4);
    chk("popedge_ready_before", 32'(ready), 0);
    dv = 1'b1; tx_byte = 8'h77;
    tick();
    dv = 1'b0;
    chk("popedge_count_after", 32'(fcount), 3);
    chk("popedge_ready_after", 32'(ready), 1);
    repeat (4*42 + 20) tick();
    chk("burst_rx_frames", 32'(rxq.size()), 5);
    for (int i = 0; i < rxq.size() && i < 5; i++) begin
      chk($sformatf("burst_rx_byte%0d", i), 32'(rxq[i].d), 32'(i + 1));
      chk($sformatf("burst_rx_stop%0d", i), 32'(rxq[i].stop), 1);
      if (i > 0) chk($sformatf("burst_period%0d", i), 32'(rxq[i].t - rxq[i-1].t), 42);
    end

    // Reset in the middle of the data bits of 0x3C with two bytes queued.
    dv = 1'b1; tx_byte = 8'h3C; tick();
    tx_byte = 8'h11; tick();
    tx_byte = 8'h22; tick();
    dv = 1'b0;
    chk("rstmid_count_queued", 32'(fcount), 2);
    repeat (13) tick();
    chk("rstmid_active_before", 32'(active), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_serial", 32'(serial), 1);
    chk("rstmid_count", 32'(fcount), 0);
    chk("rstmid_active", 32'(active), 0);
    chk("rstmid_ready", 32'(ready), 1);
    bad = 0; dseen = 0;
    for (int i = 0; i < 60; i++) begin
      if (serial !== 1'b1) bad++;
      if (done !== 1'b0) dseen++;
      tick();
    end
    chk("rstmid_line_bad_cycles", 32'(bad), 0);
    chk("rstmid_done_cycles", 32'(dseen), 0);

    // Stream 0x00..0xFF through the receiver model, pushing whenever ready.
    rxq.delete();
    for (int b = 0; b < 256; b++) begin
      w = 0;
      while (ready !== 1'b1 && w < 200) begin
        tick();
        w++;
      end
      if (w >= 200) begin
        chk("stream_ready_timeout", 32'(w), 0);
        break;
      end
      dv = 1'b1; tx_byte = 8'(b);
      tick();
      dv = 1'b0;
    end
    w = 0;
    while (rxq.size() < 256 && w < 2000) begin
      tick();
      w++;
    end
    chk("stream_rx_frames", 32'(rxq.size()), 256);
    bad = 0;
    for (int i = 0; i < rxq.size() && i < 256; i++)
      if (rxq[i].d !== 8'(i) || rxq[i].stop !== 1'b1) bad++;
    chk("stream_rx_bad_bytes", 32'(bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
